// File: rtl/nios_led_pkg.sv
// Shared definitions for the LED fader: default PWM width, full-brightness
// level, level type and the saturating fade step used by every channel.
package nios_led_pkg;

  localparam int PWM_BITS_DEFAULT = 8;
  localparam int LEVEL_MAX        = (1 << PWM_BITS_DEFAULT) - 1;

  typedef logic [PWM_BITS_DEFAULT-1:0] level_t;

  // One fade step toward the target; clamps to [0, lim] instead of wrapping.
  // Arithmetic is carried out at 32 bits, so level + step cannot overflow.
  function automatic int unsigned sat_step(input int unsigned level,
                                           input int unsigned step,
                                           input int unsigned lim,
                                           input logic        up);
    if (up) begin
      return (level + step > lim) ? lim : level + step;
    end else begin
      return (level < step) ? 0 : level - step;
    end
  endfunction

endpackage

// File: rtl/nios_led_fader_chan.sv
// One LED channel: brightness level register, saturating fade on each tick,
// optional square-law gamma (LED_FADER_GAMMA_EN) and PWM output compare.
module nios_led_fade_chan
  import nios_led_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEFAULT,
  parameter int FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                req,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] thr;

  // A channel is settled when it sits at the endpoint its request points to.
  assign at_target = req ? (level == LVL_MAX) : (level == '0);

  // Level moves one saturating step per tick toward the requested endpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else if (tick) begin
      level <= PWM_BITS'(sat_step(32'(level), FADE_STEP, 32'(LVL_MAX), req));
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;

  assign level_sq = level * level;

  // Square-law threshold, registered; full scale is pinned so that the
  // brightest level still drives a constant 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr <= '0;
    end else if (level == LVL_MAX) begin
      thr <= LVL_MAX;
    end else begin
      thr <= level_sq[2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  assign thr = level;
`endif

  // PWM compare; full scale is forced high to avoid a one-count dropout.
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 1'b0;
    end else begin
      led <= (thr == LVL_MAX) ? 1'b1 : (pwm_cnt < thr);
    end
  end

endmodule

// File: rtl/nios_led_fader.sv
// LED fader top: registers the PIO on/off word, generates the fade tick and
// the free-running PWM count, and drives one fade channel per LED.
// Optional build macro: LED_FADER_GAMMA_EN (square-law brightness curve).
module nios_led_fader
  import nios_led_pkg::*;
#(
  parameter int NUM_LEDS  = 16,
  parameter int PWM_BITS  = PWM_BITS_DEFAULT,
  parameter int TICK_DIV  = 50000,
  parameter int FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_req,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [NUM_LEDS-1:0] req_q;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] at_target;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Single register stage on the request word; source shares this clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
    end else begin
      req_q <= led_req;
    end
  end

  // Prescaler counting 0..TICK_DIV-1; tick marks the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Free-running PWM counter; its natural wrap sets the PWM period.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    nios_led_fade_chan #(
      .PWM_BITS  (PWM_BITS),
      .FADE_STEP (FADE_STEP)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .req       (req_q[i]),
      .pwm_cnt   (pwm_cnt),
      .led       (led_out[i]),
      .at_target (at_target[i])
    );
  end

  // Busy while any channel is still short of its requested endpoint.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= ~&at_target;
    end
  end

endmodule

// File: tb/tb_nios_led_fader.sv
// Scoreboard bench for nios_led_fader (TICK_DIV=4, FADE_STEP=64).
module tb_nios_led_fader;

  localparam int NL = 16;
  localparam int PB = 8;
  localparam int TD = 4;
  localparam int FS = 64;
  localparam int LM = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] led_req;
  logic [NL-1:0] led_out;
  logic          busy;

  nios_led_fader #(
    .NUM_LEDS  (NL),
    .PWM_BITS  (PB),
    .TICK_DIV  (TD),
    .FADE_STEP (FS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .led_req (led_req),
    .led_out (led_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] led;
    logic          busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: brightness per LED, fade tick phase, PWM phase.
  logic [NL-1:0] m_req;
  int            m_tick;
  int            m_pwm;
  int            m_lvl[NL];
  int            m_thr[NL];
  logic [NL-1:0] m_led;
  logic          m_busy;

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic rst, input logic [NL-1:0] req);
    logic [NL-1:0] nl;
    logic          nb;
    logic          tk;
    int            t;
    if (rst) begin
      m_req = '0; m_tick = 0; m_pwm = 0; m_led = '0; m_busy = 1'b0;
      for (int i = 0; i < NL; i++) begin
        m_lvl[i] = 0;
        m_thr[i] = 0;
      end
    end else begin
      tk = (m_tick == TD - 1);
      nl = '0;
      nb = 1'b0;
      for (int i = 0; i < NL; i++) begin
`ifdef LED_FADER_GAMMA_EN
        t = m_thr[i];
        m_thr[i] = (m_lvl[i] == LM) ? LM : (m_lvl[i] * m_lvl[i]) / 256;
`else
        t = m_lvl[i];
`endif
        nl[i] = (t == LM) ? 1'b1 : (m_pwm < t);
        if (m_req[i] ? (m_lvl[i] != LM) : (m_lvl[i] != 0)) nb = 1'b1;
        if (tk) begin
          if (m_req[i]) m_lvl[i] = (m_lvl[i] + FS > LM) ? LM : m_lvl[i] + FS;
          else          m_lvl[i] = (m_lvl[i] < FS) ? 0 : m_lvl[i] - FS;
        end
      end
      m_led  = nl;
      m_busy = nb;
      m_req  = req;
      m_tick = (m_tick + 1) % TD;
      m_pwm  = (m_pwm + 1) % 256;
    end
  endtask

  // Drive one clock of stimulus and queue the outputs it must produce.
  task automatic cycle(input logic r, input logic [NL-1:0] rq);
    exp_t e;
    reset   = r;
    led_req = rq;
    model_step(r, rq);
    e.led  = m_led;
    e.busy = m_busy;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: after every active edge, compare the DUT against the queued result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (led_out !== e.led || busy !== e.busy) begin
          errors++;
          $display("FAIL out cyc=%0d led_out=%h busy=%b expected led_out=%h busy=%b",
                   cyc, led_out, busy, e.led, e.busy);
        end
      end
    end
  end

  initial begin
    logic [NL-1:0] v;
    logic          r;
    int            h;
    int            k;
    logic          seen_busy;

    reset   = 1'b1;
    led_req = '0;
    repeat (3) cycle(1'b1, '0);

    // Ramp ch0 up to full and hold long enough to see a constant 1.
    repeat (300) cycle(1'b0, 16'h0001);
    // Ramp back down and hold dark.
    repeat (300) cycle(1'b0, 16'h0000);
    // Reversal mid-ramp.
    repeat (12) cycle(1'b0, 16'h0001);
    repeat (30) cycle(1'b0, 16'h0000);
    // Reset in the middle of a ramp, then stay dark.
    repeat (10) cycle(1'b0, 16'h0001);
    cycle(1'b1, 16'h0001);
    repeat (20) cycle(1'b0, 16'h0000);

    // Independence: only set bits ramp; busy must clear within a bounded time.
    seen_busy = 1'b0;
    k = 0;
    while (k < 40) begin
      cycle(1'b0, 16'hA5A5);
      k++;
      if (busy === 1'b1) seen_busy = 1'b1;
      if (seen_busy && busy === 1'b0) break;
    end
    checks++;
    if (!(seen_busy && busy === 1'b0)) begin
      errors++;
      $display("FAIL busy_clear busy=%b seen_busy=%b after %0d cycles, required busy rise then clear within 40",
               busy, seen_busy, k);
    end
    repeat (300) cycle(1'b0, 16'hA5A5);

    // Randomized request patterns with occasional resets.
    for (int b = 0; b < 200; b++) begin
      v = NL'($urandom);
      h = $urandom_range(1, 40);
      r = ($urandom_range(0, 49) == 0);
      cycle(r, v);
      repeat (h) cycle(1'b0, v);
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
